// File: rtl/z80_alu_ctrl.sv
// z80_alu_ctrl
//   Issue/writeback sequencer in front of z80_alu. The block takes one decoded 8-bit
//   ALU instruction per transaction and drives the ALU's op/operand/flag inputs. It
//   captures the ALU result and builds the GB-style flags {Z,N,H,C} in F[7:4]. The
//   result is handed to register-file writeback, and architectural A and F live here.
//
//   Optional feature macro: Z80_ALU_CTRL_CB_EN
//     defined   : CB-prefixed rotate/shift/swap group (CB 00-3F) is decoded.
//     undefined : every CB-prefixed instruction completes as illegal, and no CB
//                 decode logic is built.
//
//   Handshake rules (both ports, strict valid/ready):
//     A transfer happens on a rising clk edge where valid && ready are both 1.
//     Upstream: in_ready is 1 only in IDLE, and the in_* fields are sampled on that edge.
//     Downstream: once out_valid rises, out_data/out_dest_a/out_illegal hold steady
//     until the out_ready edge. A and F commit only on that edge.
//
//   Timing: accept edge -> EXEC for one cycle (ALU inputs registered) -> WB with
//   out_valid high until the downstream handshake -> IDLE. No accept can happen
//   in the handshake cycle, because in_ready is low throughout WB.
module z80_alu_ctrl #(
    parameter logic [7:0] RESET_A = 8'h00,
    parameter logic [7:0] RESET_F = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_cb,
    input  logic [7:0]  in_opcode,
    input  logic [7:0]  in_operand,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_f,
    input  logic [15:0] alu_d,
    input  logic [3:0]  alu_nf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_dest_a,
    output logic        out_illegal,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_f,
    output logic [1:0]  dbg_state_o
);

    // z80_alu operation codes
    localparam logic [4:0] OP_OR   = 5'h00;
    localparam logic [4:0] OP_AND  = 5'h01;
    localparam logic [4:0] OP_XOR  = 5'h02;
    localparam logic [4:0] OP_CPL  = 5'h03;
    localparam logic [4:0] OP_ADD  = 5'h05;
    localparam logic [4:0] OP_ADC  = 5'h06;
    localparam logic [4:0] OP_SUB  = 5'h07;
    localparam logic [4:0] OP_SBC  = 5'h08;
    localparam logic [4:0] OP_RLC  = 5'h09;
    localparam logic [4:0] OP_RL   = 5'h0a;
    localparam logic [4:0] OP_RRC  = 5'h0b;
    localparam logic [4:0] OP_RR   = 5'h0c;
`ifdef Z80_ALU_CTRL_CB_EN
    localparam logic [4:0] OP_SLA  = 5'h0d;
    localparam logic [4:0] OP_SRA  = 5'h0e;
    localparam logic [4:0] OP_SRL  = 5'h0f;
    localparam logic [4:0] OP_SWAP = 5'h10;
`endif
    localparam logic [4:0] OP_DAA  = 5'h12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // How the new {Z,N,H,C} is built once the ALU has answered
    typedef enum logic [3:0] {
        FM_NONE,   // flags unchanged (LD A,n and illegal)
        FM_ADD,    // Z,0,h,c
        FM_SUB,    // Z,1,h,c
        FM_AND,    // Z,0,1,0
        FM_LOGIC,  // Z,0,0,0
        FM_ROTA,   // 0,0,0,c
        FM_DAA,    // Z,N,0,C|c
        FM_CPL,    // -,1,1,-
        FM_SCF,    // -,0,0,1
        FM_CCF,    // -,0,0,~C
        FM_SHIFT,  // Z,0,0,c
        FM_SWAP    // Z,0,0,0
    } fmode_t;

    // Where out_data comes from
    typedef enum logic [1:0] {
        RS_ALU,
        RS_A,
        RS_OPND
    } rsrc_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q;
    logic [3:0]  f_q;
    logic [4:0]  alu_op_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    fmode_t      fm_q;
    rsrc_t       rs_q;
    logic        dest_q;
    logic        ill_q;
    logic [7:0]  opnd_q;
    logic [7:0]  out_data_q;
    logic        out_dest_q;
    logic        out_ill_q;
    logic [3:0]  f_new_q;

    logic        accept;
    logic        exec_done;
    logic        commit;

    logic [4:0]  dec_op;
    logic        dec_a_is_opnd;
    fmode_t      dec_fm;
    rsrc_t       dec_rs;
    logic        dec_dest_a;
    logic        dec_illegal;

    logic [7:0]  result_d;
    logic [3:0]  f_new_d;

    // ALU result high byte and the ALU's own Z/N guesses are not needed: Z is
    // recomputed from the result byte, and N is fixed by the instruction class.
    logic        unused_alu_bits;
    assign unused_alu_bits = ^{alu_d[15:8], alu_nf[3], alu_nf[2]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake strobes
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        exec_done = 1'b0;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec_done = 1'b1;
                state_d   = ST_WB;
            end
            ST_WB: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction decode of the offered opcode (used only on the accept edge)
    always_comb begin
        dec_op        = OP_OR;
        dec_a_is_opnd = 1'b0;
        dec_fm        = FM_NONE;
        dec_rs        = RS_A;
        dec_dest_a    = 1'b0;
        dec_illegal   = 1'b1;
        if (!in_cb) begin
            if ((in_opcode[7:6] == 2'b10) ||
                ((in_opcode[7:6] == 2'b11) && (in_opcode[2:0] == 3'b110))) begin
                // Register and immediate forms share the [5:3] operation field
                dec_illegal = 1'b0;
                dec_rs      = RS_ALU;
                dec_dest_a  = 1'b1;
                case (in_opcode[5:3])
                    3'd0: begin dec_op = OP_ADD; dec_fm = FM_ADD;   end
                    3'd1: begin dec_op = OP_ADC; dec_fm = FM_ADD;   end
                    3'd2: begin dec_op = OP_SUB; dec_fm = FM_SUB;   end
                    3'd3: begin dec_op = OP_SBC; dec_fm = FM_SUB;   end
                    3'd4: begin dec_op = OP_AND; dec_fm = FM_AND;   end
                    3'd5: begin dec_op = OP_XOR; dec_fm = FM_LOGIC; end
                    3'd6: begin dec_op = OP_OR;  dec_fm = FM_LOGIC; end
                    default: begin
                        // CP: subtract for flags only, A is left alone
                        dec_op     = OP_SUB;
                        dec_fm     = FM_SUB;
                        dec_dest_a = 1'b0;
                    end
                endcase
            end else begin
                case (in_opcode)
                    8'h07: begin dec_op = OP_RLC; dec_fm = FM_ROTA; dec_rs = RS_ALU; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    8'h17: begin dec_op = OP_RL;  dec_fm = FM_ROTA; dec_rs = RS_ALU; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    8'h0F: begin dec_op = OP_RRC; dec_fm = FM_ROTA; dec_rs = RS_ALU; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    8'h1F: begin dec_op = OP_RR;  dec_fm = FM_ROTA; dec_rs = RS_ALU; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    8'h27: begin dec_op = OP_DAA; dec_fm = FM_DAA;  dec_rs = RS_ALU; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    8'h2F: begin dec_op = OP_CPL; dec_fm = FM_CPL;  dec_rs = RS_ALU; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    // SCF/CCF only touch flags; A is written back with itself
                    8'h37: begin dec_fm = FM_SCF; dec_rs = RS_A; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    8'h3F: begin dec_fm = FM_CCF; dec_rs = RS_A; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    8'h3E: begin dec_fm = FM_NONE; dec_rs = RS_OPND; dec_dest_a = 1'b1; dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
        end
`ifdef Z80_ALU_CTRL_CB_EN
        else if (in_opcode[7:6] == 2'b00) begin
            // CB rotate/shift/swap group works on the source register value
            dec_illegal   = 1'b0;
            dec_a_is_opnd = 1'b1;
            dec_rs        = RS_ALU;
            dec_fm        = FM_SHIFT;
            dec_dest_a    = (in_opcode[2:0] == 3'd7);
            case (in_opcode[5:3])
                3'd0: dec_op = OP_RLC;
                3'd1: dec_op = OP_RRC;
                3'd2: dec_op = OP_RL;
                3'd3: dec_op = OP_RR;
                3'd4: dec_op = OP_SLA;
                3'd5: dec_op = OP_SRA;
                3'd6: begin dec_op = OP_SWAP; dec_fm = FM_SWAP; end
                default: dec_op = OP_SRL;
            endcase
        end
`endif
    end

    // Result byte and flag formation from the ALU response during EXEC
    always_comb begin
        result_d = a_q;
        case (rs_q)
            RS_ALU:  result_d = alu_d[7:0];
            RS_OPND: result_d = opnd_q;
            default: result_d = a_q;
        endcase
        f_new_d = f_q;
        case (fm_q)
            FM_ADD:   f_new_d = {(result_d == 8'h00), 1'b0, alu_nf[1], alu_nf[0]};
            FM_SUB:   f_new_d = {(result_d == 8'h00), 1'b1, alu_nf[1], alu_nf[0]};
            FM_AND:   f_new_d = {(result_d == 8'h00), 1'b0, 1'b1, 1'b0};
            FM_LOGIC: f_new_d = {(result_d == 8'h00), 1'b0, 1'b0, 1'b0};
            FM_ROTA:  f_new_d = {1'b0, 1'b0, 1'b0, alu_nf[0]};
            FM_DAA:   f_new_d = {(result_d == 8'h00), f_q[2], 1'b0, f_q[0] | alu_nf[0]};
            FM_CPL:   f_new_d = {f_q[3], 1'b1, 1'b1, f_q[0]};
            FM_SCF:   f_new_d = {f_q[3], 1'b0, 1'b0, 1'b1};
            FM_CCF:   f_new_d = {f_q[3], 1'b0, 1'b0, ~f_q[0]};
            FM_SHIFT: f_new_d = {(result_d == 8'h00), 1'b0, 1'b0, alu_nf[0]};
            FM_SWAP:  f_new_d = {(result_d == 8'h00), 1'b0, 1'b0, 1'b0};
            default:  f_new_d = f_q;
        endcase
    end

    // Datapath: latch on accept, capture at end of EXEC, commit A/F on handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= RESET_A;
            f_q        <= RESET_F[7:4];
            alu_op_q   <= OP_OR;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            fm_q       <= FM_NONE;
            rs_q       <= RS_A;
            dest_q     <= 1'b0;
            ill_q      <= 1'b0;
            opnd_q     <= 8'h00;
            out_data_q <= 8'h00;
            out_dest_q <= 1'b0;
            out_ill_q  <= 1'b0;
            f_new_q    <= RESET_F[7:4];
        end else begin
            if (accept) begin
                alu_op_q <= dec_op;
                alu_a_q  <= dec_a_is_opnd ? in_operand : a_q;
                alu_b_q  <= in_operand;
                fm_q     <= dec_fm;
                rs_q     <= dec_rs;
                dest_q   <= dec_dest_a;
                ill_q    <= dec_illegal;
                opnd_q   <= in_operand;
            end
            if (exec_done) begin
                out_data_q <= result_d;
                f_new_q    <= f_new_d;
                out_dest_q <= dest_q;
                out_ill_q  <= ill_q;
            end
            if (commit) begin
                if (out_dest_q && !out_ill_q) begin
                    a_q <= out_data_q;
                end
                f_q <= f_new_q;
            end
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_a       = {8'h00, alu_a_q};
    assign alu_b       = {8'h00, alu_b_q};
    assign alu_f       = f_q;
    assign out_data    = out_data_q;
    assign out_dest_a  = out_dest_q;
    assign out_illegal = out_ill_q;
    assign reg_a       = a_q;
    assign reg_f       = {f_q, 4'h0};
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_z80_alu_ctrl.sv
// Bench for z80_alu_ctrl: a behavioural z80_alu stub answers the controller, and
// an instruction-level reference model predicts out_data/out_dest_a/out_illegal
// and the architectural A/F after each transaction.
module tb_z80_alu_ctrl;

  localparam logic [7:0] P_RESET_A = 8'h5A;
  localparam logic [7:0] P_RESET_F = 8'hB7;
`ifdef Z80_ALU_CTRL_CB_EN
  localparam bit CB_ON = 1'b1;
`else
  localparam bit CB_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_cb;
  logic [7:0]  in_opcode;
  logic [7:0]  in_operand;
  logic [4:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_f;
  logic [15:0] alu_d;
  logic [3:0]  alu_nf;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_dest_a;
  logic        out_illegal;
  logic [7:0]  reg_a;
  logic [7:0]  reg_f;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_bad    = 0;

  logic [9:0]  exp_q[$];
  logic [7:0]  m_a;
  logic [7:0]  m_f;
  logic [9:0]  last_out;
  logic [11:0] alu_resp;

  z80_alu_ctrl #(
    .RESET_A(P_RESET_A),
    .RESET_F(P_RESET_F)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cb(in_cb),
    .in_opcode(in_opcode), .in_operand(in_operand),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_d(alu_d), .alu_nf(alu_nf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest_a(out_dest_a), .out_illegal(out_illegal),
    .reg_a(reg_a), .reg_f(reg_f), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // z80_alu stub: {nf, d} from op and operands; high result byte is junk on purpose
  function automatic logic [11:0] alu_model(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [3:0] f);
    int s; int cin; logic [7:0] r; logic h; logic c;
    r = 8'h00; h = 1'b0; c = 1'b0; s = 0;
    cin = f[0] ? 1 : 0;
    case (op)
      5'h00: r = a | b;
      5'h01: begin r = a & b; h = 1'b1; end
      5'h02: r = a ^ b;
      5'h03: begin r = ~a; h = 1'b1; end
      5'h05, 5'h06: begin
        if (op == 5'h05) cin = 0;
        s = int'(a) + int'(b) + cin; r = s[7:0]; c = (s > 255);
        h = (int'(a[3:0]) + int'(b[3:0]) + cin) > 15;
      end
      5'h07, 5'h08: begin
        if (op == 5'h07) cin = 0;
        s = int'(a) - int'(b) - cin; r = s[7:0]; c = (s < 0);
        h = (int'(a[3:0]) - int'(b[3:0]) - cin) < 0;
      end
      5'h09: begin r = {a[6:0], a[7]}; c = a[7]; end
      5'h0a: begin r = {a[6:0], f[0]}; c = a[7]; end
      5'h0b: begin r = {a[0], a[7:1]}; c = a[0]; end
      5'h0c: begin r = {f[0], a[7:1]}; c = a[0]; end
      5'h0d: begin r = {a[6:0], 1'b0}; c = a[7]; end
      5'h0e: begin r = {a[7], a[7:1]}; c = a[0]; end
      5'h0f: begin r = {1'b0, a[7:1]}; c = a[0]; end
      5'h10: r = {a[3:0], a[7:4]};
      5'h12: begin
        r = a;
        if (!f[2]) begin
          if (f[0] || a > 8'h99) begin r = r + 8'h60; c = 1'b1; end
          if (f[1] || a[3:0] > 4'h9) r = r + 8'h06;
        end else begin
          if (f[0]) r = r - 8'h60;
          if (f[1]) r = r - 8'h06;
        end
      end
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), 1'b0, h, c, r};
  endfunction

  always_comb begin
    alu_resp = alu_model(alu_op, alu_a[7:0], alu_b[7:0], alu_f);
    alu_nf   = alu_resp[11:8];
    alu_d    = {8'hA5, alu_resp[7:0]};
  end

  // Reference model, instruction level: returns {ill, dest, data, new_a, new_f}
  function automatic logic [25:0] model_step(input logic cb, input logic [7:0] opc,
                                             input logic [7:0] opd, input logic [7:0] a,
                                             input logic [7:0] f);
    logic z, n, h, c, ill, dest; logic [7:0] data; int res; int cin; logic [7:0] na;
    z = f[7]; n = f[6]; h = f[5]; c = f[4];
    ill = 1'b1; dest = 1'b0; data = a; res = 0;
    if (!cb) begin
      if (opc[7:6] == 2'b10 || (opc[7:6] == 2'b11 && opc[2:0] == 3'b110)) begin
        ill = 1'b0; dest = 1'b1;
        cin = ((opc[5:3] == 3'd1 || opc[5:3] == 3'd3) && c) ? 1 : 0;
        case (opc[5:3])
          3'd0, 3'd1: begin
            res = int'(a) + int'(opd) + cin;
            h = (int'(a[3:0]) + int'(opd[3:0]) + cin) > 15; c = res > 255; n = 1'b0;
          end
          3'd4: begin res = int'(a & opd); n = 1'b0; h = 1'b1; c = 1'b0; end
          3'd5: begin res = int'(a ^ opd); n = 1'b0; h = 1'b0; c = 1'b0; end
          3'd6: begin res = int'(a | opd); n = 1'b0; h = 1'b0; c = 1'b0; end
          default: begin
            res = int'(a) - int'(opd) - cin;
            h = (int'(a[3:0]) - int'(opd[3:0]) - cin) < 0; c = res < 0; n = 1'b1;
            if (opc[5:3] == 3'd7) dest = 1'b0;
          end
        endcase
        data = res[7:0];
        z = (data == 8'h00);
      end else begin
        case (opc)
          8'h07: begin data = {a[6:0], a[7]}; c = a[7]; z = 1'b0; n = 1'b0; h = 1'b0; ill = 1'b0; dest = 1'b1; end
          8'h17: begin data = {a[6:0], c};    c = a[7]; z = 1'b0; n = 1'b0; h = 1'b0; ill = 1'b0; dest = 1'b1; end
          8'h0F: begin data = {a[0], a[7:1]}; c = a[0]; z = 1'b0; n = 1'b0; h = 1'b0; ill = 1'b0; dest = 1'b1; end
          8'h1F: begin data = {c, a[7:1]};    c = a[0]; z = 1'b0; n = 1'b0; h = 1'b0; ill = 1'b0; dest = 1'b1; end
          8'h27: begin
            data = a;
            if (!n) begin
              if (c || a > 8'h99) begin data = data + 8'h60; c = 1'b1; end
              if (h || a[3:0] > 4'h9) data = data + 8'h06;
            end else begin
              if (c) data = data - 8'h60;
              if (h) data = data - 8'h06;
            end
            z = (data == 8'h00); h = 1'b0; ill = 1'b0; dest = 1'b1;
          end
          8'h2F: begin data = ~a; n = 1'b1; h = 1'b1; ill = 1'b0; dest = 1'b1; end
          8'h37: begin n = 1'b0; h = 1'b0; c = 1'b1; ill = 1'b0; dest = 1'b1; end
          8'h3F: begin n = 1'b0; h = 1'b0; c = ~c; ill = 1'b0; dest = 1'b1; end
          8'h3E: begin data = opd; ill = 1'b0; dest = 1'b1; end
          default: ;
        endcase
      end
    end else if (CB_ON && opc < 8'h40) begin
      ill = 1'b0; dest = (opc[2:0] == 3'd7);
      case (opc[5:3])
        3'd0: begin data = {opd[6:0], opd[7]}; c = opd[7]; end
        3'd1: begin data = {opd[0], opd[7:1]}; c = opd[0]; end
        3'd2: begin data = {opd[6:0], c};      c = opd[7]; end
        3'd3: begin data = {c, opd[7:1]};      c = opd[0]; end
        3'd4: begin data = {opd[6:0], 1'b0};   c = opd[7]; end
        3'd5: begin data = {opd[7], opd[7:1]}; c = opd[0]; end
        3'd6: begin data = {opd[3:0], opd[7:4]}; c = 1'b0; end
        default: begin data = {1'b0, opd[7:1]}; c = opd[0]; end
      endcase
      z = (data == 8'h00); n = 1'b0; h = 1'b0;
    end
    na = (dest && !ill) ? data : a;
    return {ill, dest, data, na, z, n, h, c, 4'h0};
  endfunction

  // single checking task: every comparison goes through here
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver + scoreboard for one transaction; called at a negedge in IDLE
  task automatic run_txn(input logic cb, input logic [7:0] opc, input logic [7:0] opd,
                         input int stall);
    logic [25:0] m;
    logic [9:0]  e;
    int t;
    m = model_step(cb, opc, opd, m_a, m_f);
    exp_q.push_back(m[25:16]);
    check_val("idle_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1; in_cb = cb; in_opcode = opc; in_operand = opd;
    @(negedge clk);
    in_valid = 1'b0; in_cb = 1'($urandom); in_opcode = 8'($urandom); in_operand = 8'($urandom);
    check_val("exec_valid", {15'd0, out_valid}, 16'd0);
    check_val("exec_ready", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 8) begin
      @(negedge clk);
      t++;
    end
    check_val("wb_latency", 16'(t), 16'd0);
    e = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      check_val("stall_valid", {15'd0, out_valid}, 16'd1);
      check_val("stall_ready", {15'd0, in_ready}, 16'd0);
      check_val("stall_data", {8'd0, out_data}, {8'd0, e[7:0]});
      check_val("stall_a", {8'd0, reg_a}, {8'd0, m_a});
      @(negedge clk);
    end
    last_out = {out_illegal, out_dest_a, out_data};
    check_val("wb_out", {6'd0, last_out}, {6'd0, e});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    t = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    m_a = m[15:8];
    m_f = m[7:0];
    check_val("post_valid", {15'd0, out_valid}, 16'd0);
    check_val("post_idle", {14'd0, dbg_state}, 16'd0);
    check_val("post_a", {8'd0, reg_a}, {8'd0, m_a});
    check_val("post_f", {8'd0, reg_f}, {8'd0, m_f});
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_state"}, {14'd0, dbg_state}, 16'd0);
    check_val({tag, "_valid"}, {15'd0, out_valid}, 16'd0);
    check_val({tag, "_a"}, {8'd0, reg_a}, {8'd0, P_RESET_A});
    check_val({tag, "_f"}, {8'd0, reg_f}, 16'h00B0);
    check_val({tag, "_out"}, {6'd0, out_illegal, out_dest_a, out_data}, 16'd0);
    check_val({tag, "_aluop"}, {11'd0, alu_op}, 16'd0);
    check_val({tag, "_alua"}, alu_a, 16'd0);
    check_val({tag, "_alub"}, alu_b, 16'd0);
  endtask

  logic [7:0] single_ops [17];

  initial begin
    single_ops = '{8'h07, 8'h17, 8'h0F, 8'h1F, 8'h27, 8'h2F, 8'h37, 8'h3F, 8'h3E,
                   8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE};
    reset = 1'b1; in_valid = 1'b0; in_cb = 1'b0; in_opcode = 8'h00; in_operand = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_a = P_RESET_A;
    m_f = P_RESET_F & 8'hF0;
    check_reset_state("rst");

    // 1: LD A,3A; ADD 80 with C6
    run_txn(1'b0, 8'h3E, 8'h3A, 0);
    run_txn(1'b0, 8'h80, 8'hC6, 0);
    check_val("t1_data", {8'd0, last_out[7:0]}, 16'h0000);
    check_val("t1_f", {8'd0, reg_f}, 16'h00B0);
    check_val("t1_a", {8'd0, reg_a}, 16'h0000);

    // 2: LD A,3E; SUB 3E; LD A,3C; CP 40
    run_txn(1'b0, 8'h3E, 8'h3E, 0);
    run_txn(1'b0, 8'h90, 8'h3E, 1);
    check_val("t2_sub_f", {8'd0, reg_f}, 16'h00C0);
    run_txn(1'b0, 8'h3E, 8'h3C, 0);
    run_txn(1'b0, 8'hB8, 8'h40, 0);
    check_val("t2_cp_a", {8'd0, reg_a}, 16'h003C);
    check_val("t2_cp_f", {8'd0, reg_f}, 16'h0050);

    // 3: LD A,45; ADD 38; DAA
    run_txn(1'b0, 8'h3E, 8'h45, 0);
    run_txn(1'b0, 8'h80, 8'h38, 0);
    check_val("t3_add_a", {8'd0, reg_a}, 16'h007D);
    check_val("t3_add_f", {8'd0, reg_f}, 16'h0000);
    run_txn(1'b0, 8'h27, 8'h00, 0);
    check_val("t3_daa_a", {8'd0, reg_a}, 16'h0083);
    check_val("t3_daa_f", {8'd0, reg_f}, 16'h0000);

    // 4: CB 00 (RLC B) on 85
    run_txn(1'b1, 8'h00, 8'h85, 0);
    check_val("t4_out", {6'd0, last_out}, CB_ON ? 16'h000B : 16'h0283);
    check_val("t4_f", {8'd0, reg_f}, CB_ON ? 16'h0010 : 16'h0000);
    check_val("t4_a", {8'd0, reg_a}, 16'h0083);

    // 5: five stall cycles in WB
    run_txn(1'b0, 8'hC6, 8'h11, 5);
    check_val("t5_a", {8'd0, reg_a}, 16'h0094);

    // 6: reset while in EXEC discards the transaction
    in_valid = 1'b1; in_cb = 1'b0; in_opcode = 8'h3E; in_operand = 8'hEE;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("t6_exec", {14'd0, dbg_state}, 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("t6");
    m_a = P_RESET_A;
    m_f = P_RESET_F & 8'hF0;

    // randomized traffic
    for (int k = 0; k < 250; k++) begin
      logic cb; logic [7:0] opc; int sel;
      sel = $urandom_range(0, 3);
      cb = 1'b0;
      case (sel)
        0: opc = 8'($urandom);
        1: opc = 8'($urandom_range(8'h80, 8'hBF));
        2: opc = single_ops[$urandom_range(0, 16)];
        default: begin cb = 1'b1; opc = 8'($urandom_range(0, 8'h4F)); end
      endcase
      run_txn(cb, opc, 8'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
